// File: rtl/param_readback_tx.sv
// Snapshots the pulse-parameter set on req and sends it as a 20-byte 8N1 packet: HEADER, 18 payload bytes, CHK.
// Latency: tx start bit 1 cycle after accept, done 200*CLKS_PER_BIT cycles later; no backpressure, req dropped while busy.
module param_readback_tx #(
    parameter int          CLKS_PER_BIT = 1250,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [31:0] per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [15:0] nut_d,
    input  logic [7:0]  nut_w,
    input  logic [7:0]  cp,
    input  logic [7:0]  p_bl,
    input  logic [15:0] p_bl_hf,
    input  logic        bl,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_BYTE = 5'd19;
    localparam logic [4:0]    CHK_BYTE  = 5'd18;
    localparam int            NUM_PAY   = 18;

    // Field order here is the wire order of the payload, MSB first.
    typedef struct packed {
        logic [31:0] per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [15:0] nut_d;
        logic [7:0]  nut_w;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_hf;
        logic [6:0]  pad;
        logic        bl;
    } snap_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t          state;
    snap_t           snap;
    snap_t           snap_in;
    logic [143:0]    snap_vec;
    logic [7:0]      pay [NUM_PAY];
    logic [7:0]      pay_byte;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [4:0]      byte_idx;
    logic [7:0]      shreg;
    logic [7:0]      chk;

    always_comb begin
        snap_in.per     = per;
        snap_in.p1wid   = p1wid;
        snap_in.del     = del;
        snap_in.p2wid   = p2wid;
        snap_in.nut_d   = nut_d;
        snap_in.nut_w   = nut_w;
        snap_in.cp      = cp;
        snap_in.p_bl    = p_bl;
        snap_in.p_bl_hf = p_bl_hf;
        snap_in.pad     = 7'd0;
        snap_in.bl      = bl;
    end

    assign snap_vec = snap;

    always_comb begin
        for (int i = 0; i < NUM_PAY; i++) begin
            pay[i] = snap_vec[143 - 8*i -: 8];
        end
    end

    // byte_idx is the byte currently on the wire, so pay[byte_idx] is the next payload byte.
    always_comb begin
        pay_byte = 8'd0;
        if (byte_idx < CHK_BYTE) begin
            pay_byte = pay[byte_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            chk      <= '0;
            snap     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        snap     <= snap_in;
                        shreg    <= HEADER;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= BAUD_MAX;
                        byte_idx <= '0;
                        chk      <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == '0) begin
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_MAX;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_MAX;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == '0) begin
                        if (byte_idx == LAST_BYTE) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                            tx       <= 1'b0;
                            baud_cnt <= BAUD_MAX;
                            state    <= S_START;
                            // chk already holds all 18 payload bytes when the last slot loads.
                            if (byte_idx == CHK_BYTE) begin
                                shreg <= chk;
                            end else begin
                                shreg <= pay_byte;
                                chk   <= chk + pay_byte;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_readback_tx.sv
// Randomized bench for param_readback_tx: a wire-level UART decoder feeds a scoreboard of expected packets.
module tb_param_readback_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic [31:0] per = '0;
    logic [15:0] p1wid = '0, del = '0, p2wid = '0, nut_d = '0, p_bl_hf = '0;
    logic [7:0]  nut_w = '0, cp = '0, p_bl = '0;
    logic        bl = 1'b0;
    logic        tx, busy, done;

    param_readback_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
        .clk(clk), .resetn(resetn), .req(req),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .nut_d(nut_d),
        .nut_w(nut_w), .cp(cp), .p_bl(p_bl), .p_bl_hf(p_bl_hf), .bl(bl),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef logic [0:19][7:0] pkt_t;

    int         total = 0;
    int         bad = 0;
    pkt_t       exp_q[$];
    logic [7:0] rx_q[$];
    int         cur_acc = -1;
    int         cur_done = -1;
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference packet straight from the field list: header, MSB-first fields, sum of payload mod 256.
    function automatic pkt_t build_pkt();
        pkt_t p;
        int   s;
        p[0]  = 8'hA5;
        p[1]  = per[31:24];   p[2]  = per[23:16];
        p[3]  = per[15:8];    p[4]  = per[7:0];
        p[5]  = p1wid[15:8];  p[6]  = p1wid[7:0];
        p[7]  = del[15:8];    p[8]  = del[7:0];
        p[9]  = p2wid[15:8];  p[10] = p2wid[7:0];
        p[11] = nut_d[15:8];  p[12] = nut_d[7:0];
        p[13] = nut_w;        p[14] = cp;           p[15] = p_bl;
        p[16] = p_bl_hf[15:8]; p[17] = p_bl_hf[7:0];
        p[18] = {7'd0, bl};
        s = 0;
        for (int i = 1; i <= 18; i++) s += int'(p[i]);
        p[19] = 8'(s % 256);
        return p;
    endfunction

    // UART decoder: samples each bit in the middle of its CLKS_PER_BIT window.
    bit         dec_act = 1'b0;
    int         dec_p = 0;
    logic [7:0] dec_b = '0;
    always @(negedge clk) begin
        if (!resetn) begin
            dec_act = 1'b0;
            rx_q.delete();
        end else if (!dec_act) begin
            if (chk_en && tx === 1'b0) begin
                dec_act = 1'b1;
                dec_p   = 0;
            end
        end else begin
            dec_p++;
            if (dec_p == C/2) check("start_bit", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++)
                if (dec_p == C*(1+i) + C/2) dec_b[i] = tx;
            if (dec_p == 9*C + C/2) begin
                check("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(dec_b);
                dec_act = 1'b0;
            end
        end
    end

    // Monitor: busy/done/idle-tx against the model timeline, packet compare on done.
    bit   m_busy;
    pkt_t m_exp;
    always @(negedge clk) begin
        if (chk_en && resetn) begin
            m_busy = (cur_acc >= 0) && (cyc >= cur_acc) && (cyc <= cur_done);
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(cyc == cur_done));
            if (!m_busy) check("tx_idle", 32'(tx), 32'd1);
            if (cyc == cur_done && exp_q.size() > 0) begin
                m_exp = exp_q.pop_front();
                check("rx_len", rx_q.size(), 32'd20);
                for (int i = 0; i < 20; i++) begin
                    if (i < rx_q.size()) check($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(m_exp[i]));
                end
                rx_q.delete();
            end
        end
    end

    // Called right after a negedge; req is held for exactly one rising edge.
    task automatic issue(input bit chg);
        bit acc;
        req = 1'b1;
        acc = (cyc >= cur_done + 1);
        if (acc) begin
            exp_q.push_back(build_pkt());
            cur_acc  = cyc + 1;
            cur_done = cyc + 1 + 200*C;
        end
        @(negedge clk);
        req = 1'b0;
        if (acc) check("tx_start", 32'(tx), 32'd0);
        if (chg) begin
            per = '0; p1wid = '0; del = '0; p2wid = '0; nut_d = '0;
            nut_w = '0; cp = '0; p_bl = '0; p_bl_hf = '0; bl = 1'b0;
        end
    endtask

    task automatic wait_done();
        while (cyc <= cur_done + 1) @(negedge clk);
    endtask

    task automatic rand_params();
        per = $urandom; p1wid = 16'($urandom); del = 16'($urandom);
        p2wid = 16'($urandom); nut_d = 16'($urandom); nut_w = 8'($urandom);
        cp = 8'($urandom); p_bl = 8'($urandom); p_bl_hf = 16'($urandom);
        bl = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        req    = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        req    = 1'b0;
        resetn = 1'b1;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);

        issue(1'b0);
        wait_done();

        per = 32'h00010203; p1wid = 16'h0405; del = 16'h0607; p2wid = 16'h0809;
        nut_d = 16'h0A0B; nut_w = 8'h0C; cp = 8'h0D; p_bl = 8'h0E; p_bl_hf = 16'h0F10; bl = 1'b1;
        issue(1'b0);
        wait_done();

        per = 32'hFFFFFFFF; p1wid = 16'hFFFF; del = 16'hFFFF; p2wid = 16'hFFFF;
        nut_d = 16'hFFFF; nut_w = 8'hFF; cp = 8'hFF; p_bl = 8'hFF; p_bl_hf = 16'hFFFF; bl = 1'b1;
        issue(1'b1);
        wait_done();

        rand_params();
        issue(1'b0);
        repeat (300) @(negedge clk);
        rand_params();
        issue(1'b0);
        while (cyc < cur_done) @(negedge clk);
        issue(1'b0);
        rand_params();
        issue(1'b0);
        wait_done();

        rand_params();
        issue(1'b0);
        while (cyc < cur_acc + 73*C) @(negedge clk);
        resetn = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        cur_acc  = -1;
        cur_done = -1;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        rand_params();
        issue(1'b0);
        wait_done();

        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            rand_params();
            issue(1'b0);
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
